mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 op_i  in  7  opcode of the instruction register.
REQ-005 funct3_i  in  3; funct7b5_i  in  1  instruction function fields.
REQ-006 zero_i  in  1  ALU zero flag.
REQ-007 mem_ready_i  in  1  shared memory completes the current access this cycle.
REQ-008 mem_req_o  out  1  memory access request.
REQ-009 adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write_o  out  1  memory write enable.
REQ-011 ir_write_o, pc_write_o, reg_write_o  out  1 each  register load enables.
REQ-012 result_src_o  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-013 alu_src_a_o  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-014 alu_src_b_o  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-015 alu_control_o  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt.
REQ-016 imm_src_o  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-017 retire_o  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-018 illegal_o  out  1  unsupported opcode trapped.
REQ-019 state_o  out  4  current state encoding, for debug.

Function
REQ-020 The FSM SHALL use these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, ILLEGAL=11.
REQ-021 All outputs SHALL be combinational from state and inputs (Moore, plus the ready/zero qualifiers below); no output registers.
REQ-022 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10; ir_write and pc_write=1 only when mem_ready_i=1; hold FETCH until ready, then go to DECODE.
REQ-023 DECODE: alu_src_a=01, alu_src_b=01, add (branch target). Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other -> ILLEGAL
REQ-024 MEMADR: alu_src_a=10, alu_src_b=01, add; next state MEMREAD if op=0000011, else MEMWRITE.
REQ-025 MEMREAD: mem_req=1, adr_src=1, result_src=00; hold until ready, then go to MEMWB.
REQ-026 MEMWB: result_src=01, reg_write=1, retire=1; next state FETCH.
REQ-027 MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; hold until ready; on ready assert retire=1 and go to FETCH.
REQ-028 EXECR: alu_src_a=10, alu_src_b=00, ALU op from funct decode; EXECI: alu_src_a=10, alu_src_b=01, ALU op from funct decode; both go to ALUWB.
REQ-029 ALUWB: result_src=00, reg_write=1, retire=1; next state FETCH.
REQ-030 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1; next state ALUWB.
REQ-031 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero_i, retire=1; next state FETCH.
REQ-032 Funct decode for EXECR/EXECI:
- funct3 000: sub only if R-type and funct7b5=1, else add
- funct3 010: slt; 110: or; 111: and
- any other funct3 in EXECR/EXECI: next state ILLEGAL instead of ALUWB
REQ-033 imm_src_o SHALL decode from op_i in every state: I for load/OP-IMM, S for store, B for branch, J for jal, 00 otherwise.
REQ-034 ILLEGAL: all enables and mem_req=0, illegal_o=1; no exit except reset.
REQ-035 Enables not listed for a state SHALL be 0; the select fields in those states are 00.
REQ-036 Wait states of any length SHALL leave every enable unchanged except the ready-qualified ones.

Reset
REQ-037 While reset=1: state=FETCH, all enables 0 (mem_req=1 allowed), illegal_o=0.
REQ-038 Reset asserted mid-instruction SHALL abort it with no register, PC or memory write and no retire; execution restarts in FETCH.

Structure
REQ-039 A shared package SHALL hold the state enum, opcode constants, ALU control codes, and the src/result/imm select encodings.
REQ-040 Funct decode SHALL be a combinational sub-module named mc_alu_dec.

Verification
REQ-041 add x3,x1,x2 with ready always 1 -> states 0,1,6,7; retire on cycle 4; alu_control=0000.
REQ-042 lw with ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_req=1 throughout, reg_write only in MEMWB.
REQ-043 beq with zero_i=1, then repeated with zero_i=0 -> pc_write=1 in BEQ only for the first; retire in both.
REQ-044 Opcode 0001111 -> ILLEGAL after DECODE; illegal_o stays 1 for 20 cycles; reset returns to FETCH.
REQ-045 sw with reset asserted while in MEMWRITE -> mem_write_o drops in the same cycle; no retire.
REQ-046 R-type funct3=000 with funct7b5=1 -> sub (0001); I-type with the same bits -> add (0000).

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle RISC-V controller: states, opcodes,
// ALU codes and the datapath select encodings.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM: imm_src_of = IMM_I;
      OP_STORE:        imm_src_of = IMM_S;
      OP_BRANCH:       imm_src_of = IMM_B;
      OP_JAL:          imm_src_of = IMM_J;
      default:         imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode from funct3/funct7b5 for R-type and OP-IMM execution.
// Purely combinational; legal_o flags funct3 values this core does not implement.
module mc_alu_dec
  import mc_controller_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output logic [3:0] alu_control_o,
  output logic       legal_o
);

  // funct3 selects the operation; funct7b5 only distinguishes sub from add for R-type
  always_comb begin
    alu_control_o = ALU_ADD;
    legal_o       = 1'b1;
    case (funct3_i)
      3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control_o = ALU_SLT;
      3'b110:  alu_control_o = ALU_OR;
      3'b111:  alu_control_o = ALU_AND;
      default: legal_o       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM driving a shared-memory datapath.
// Outputs are combinational from state and inputs; reset masks every write enable
// immediately so an aborted instruction never commits.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_control_o,
  output logic [1:0] imm_src_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e     state_q, state_d;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       mem_write, ir_write, pc_write, reg_write, retire, illegal;

  mc_alu_dec u_alu_dec (
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .is_rtype_i    (state_q == S_EXECR),
    .alu_control_o (dec_alu),
    .legal_o       (dec_legal)
  );

  // State register; reset forces FETCH asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state: memory states hold until ready, ILLEGAL is terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = dec_legal ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_ILLEGAL;
    endcase
  end

  // Per-state datapath controls; anything not driven by a state stays 0/00
  always_comb begin
    mem_req_o     = 1'b0;
    adr_src_o     = ADR_PC;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src_o  = RES_ALUOUT;
    alu_src_a_o   = SRC_A_PC;
    alu_src_b_o   = SRC_B_RS2;
    alu_control_o = ALU_ADD;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = SRC_B_FOUR;
        result_src_o = RES_ALU;
        ir_write     = mem_ready_i;
        pc_write     = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = ADR_ALUOUT;
      end
      S_MEMWB: begin
        result_src_o = RES_RDATA;
        reg_write    = 1'b1;
        retire       = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o = 1'b1;
        adr_src_o = ADR_ALUOUT;
        mem_write = 1'b1;
        retire    = mem_ready_i;
      end
      S_EXECR: begin
        alu_src_a_o   = SRC_A_RS1;
        alu_control_o = dec_alu;
      end
      S_EXECI: begin
        alu_src_a_o   = SRC_A_RS1;
        alu_src_b_o   = SRC_B_IMM;
        alu_control_o = dec_alu;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_FOUR;
        pc_write    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o   = SRC_A_RS1;
        alu_control_o = ALU_SUB;
        pc_write      = zero_i;
        retire        = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  // Reset gates enables combinationally so a write in flight drops the same cycle
  assign mem_write_o = mem_write & ~reset;
  assign ir_write_o  = ir_write  & ~reset;
  assign pc_write_o  = pc_write  & ~reset;
  assign reg_write_o = reg_write & ~reset;
  assign retire_o    = retire    & ~reset;
  assign illegal_o   = illegal   & ~reset;
  assign imm_src_o   = imm_src_of(op_i);
  assign state_o     = state_q;

endmodule
